// File: rtl/hs4_byte_feeder_pkg.sv
// Shared types for the byte feeder: FSM states and the buffered entry layout.
package hs4_byte_feeder_pkg;

    localparam int unsigned ENTRY_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    typedef struct packed {
        logic       reset_hash;
        logic       is_key;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/hs4_byte_feeder_if.sv
// Upstream valid/ready stream plus the 4-phase cipher-side handshake.
interface hs4_byte_feeder_if;

    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_byte;
    logic       s_is_key;
    logic       s_reset_hash;

    logic [7:0] input_byte;
    logic       is_key;
    logic       reset_hash;
    logic       input_request;
    logic       input_acknowledged;

    modport master (
        input  s_valid, s_byte, s_is_key, s_reset_hash, input_acknowledged,
        output s_ready, input_byte, is_key, reset_hash, input_request
    );

    modport slave (
        output s_valid, s_byte, s_is_key, s_reset_hash, input_acknowledged,
        input  s_ready, input_byte, is_key, reset_hash, input_request
    );

endinterface

// File: rtl/hs4_byte_feeder_sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module hs4_byte_feeder_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/hs4_byte_feeder.sv
// Buffers tagged bytes and replays each to the cipher over a 4-phase req/ack handshake,
// with a sticky stall-timeout flag and a completed-handshake counter.
module hs4_byte_feeder
    import hs4_byte_feeder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    hs4_byte_feeder_if.master  bus,
    input  logic               err_clear,
    output logic               err,
    output logic [CNT_W-1:0]   sent_count
);

    localparam int unsigned TCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TLIM = TCNT_W'(TIMEOUT);

    state_t              state, state_next;
    entry_t              wr_entry, head, out_q;
    logic [ENTRY_W-1:0]  head_bits;
    logic                full, empty, push, pop, load, done;
    logic                req_q, in_timed, err_set;
    logic [TCNT_W-1:0]   tcnt, tcnt_inc, tcnt_next;

    assign wr_entry = '{reset_hash: bus.s_reset_hash, is_key: bus.s_is_key, data: bus.s_byte};
    assign push     = bus.s_valid && !full;
    assign head     = entry_t'(head_bits);

    assign bus.s_ready       = !full;
    assign bus.input_byte    = out_q.data;
    assign bus.is_key        = out_q.is_key;
    assign bus.reset_hash    = out_q.reset_hash;
    assign bus.input_request = req_q;

    hs4_byte_feeder_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head_bits),
        .full    (full),
        .empty   (empty)
    );

    // Next-state, FIFO pop, and stall-timer logic.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = SETUP;
                    load       = 1'b1;
                end
            end
            SETUP: state_next = REQ;
            REQ: begin
                if (bus.input_acknowledged) begin
                    state_next = WAIT_LO;
                    pop        = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!bus.input_acknowledged) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        in_timed = (state == REQ) || (state == WAIT_LO);
        tcnt_inc = (tcnt < TLIM) ? tcnt + TCNT_W'(1) : tcnt;
        err_set  = in_timed && (TIMEOUT != 0) && (tcnt_inc == TLIM);
        if (state_next != state) begin
            tcnt_next = '0;
        end else if (in_timed) begin
            tcnt_next = tcnt_inc;
        end else begin
            tcnt_next = tcnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            out_q      <= '0;
            tcnt       <= '0;
            err        <= 1'b0;
            sent_count <= '0;
        end else begin
            state <= state_next;
            req_q <= (state_next == REQ);
            tcnt  <= tcnt_next;
            if (load) out_q <= head;
            // A fresh timeout outranks a clear in the same cycle.
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clear) begin
                err <= 1'b0;
            end
            if (done) sent_count <= sent_count + CNT_W'(1);
        end
    end

endmodule
